// File: rtl/matrix_seq_ctrl_if.sv
// matrix_seq_ctrl_if: message-load, playback-control and display-side signals of matrix_seq_ctrl.
// Defining MATRIX_SEQ_REVERSE_EN adds the dir input.
interface matrix_seq_ctrl_if #(parameter int MSG_DEPTH = 16);
  localparam int AW = $clog2(MSG_DEPTH);
  logic          wr_en;
  logic [3:0]    wr_data;
  logic          clear;
  logic          start;
  logic          stop;
  logic          loop;
  logic          ce;
  logic [3:0]    seq;
  logic          busy;
  logic          done;
  logic          full;
  logic [AW:0]   msg_len;
`ifdef MATRIX_SEQ_REVERSE_EN
  logic          dir;
  modport master (output wr_en, wr_data, clear, start, stop, loop, dir,
                  input ce, seq, busy, done, full, msg_len);
  modport slave  (input wr_en, wr_data, clear, start, stop, loop, dir,
                  output ce, seq, busy, done, full, msg_len);
`else
  modport master (output wr_en, wr_data, clear, start, stop, loop,
                  input ce, seq, busy, done, full, msg_len);
  modport slave  (input wr_en, wr_data, clear, start, stop, loop,
                  output ce, seq, busy, done, full, msg_len);
`endif
endinterface

// File: rtl/matrix_seq_ctrl.sv
// matrix_seq_ctrl: CE prescaler and hex-digit message sequencer for the 8x8 matrix display driver.
// Optional MATRIX_SEQ_REVERSE_EN adds a dir input selecting backward playback.
module matrix_seq_ctrl #(
  parameter int         CE_DIV       = 4096,
  parameter int         DWELL_FRAMES = 64,
  parameter int         MSG_DEPTH    = 16,
  parameter logic [3:0] IDLE_DIGIT   = 4'h0
) (
  input logic             clk,
  input logic             rst,
  matrix_seq_ctrl_if.slave bus
);
  localparam int AW = $clog2(MSG_DEPTH);
  localparam int PW = $clog2(CE_DIV);
  localparam int DW = DWELL_FRAMES > 1 ? $clog2(DWELL_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state, w_state;
  logic [PW-1:0] r_pre;
  logic [2:0]    r_phase;
  logic [DW-1:0] r_dwell, w_dwell;
  logic [AW-1:0] r_idx, w_idx, w_first, w_next, w_wrap, w_lastpos;
  logic [AW:0]   r_len;
  logic [3:0]    r_buf [MSG_DEPTH];
  logic [3:0]    r_seq, w_seq;
  logic          r_done, w_done;
  logic          w_ce, w_frame_end, w_full, w_wr, w_go, w_at_end, w_sdir, w_rdir;

`ifdef MATRIX_SEQ_REVERSE_EN
  logic r_dir;
  always_ff @(posedge clk)
    if (rst) r_dir <= 1'b0;
    else if (!bus.clear && !bus.stop && w_go) r_dir <= bus.dir;
  assign w_sdir = bus.dir;
  assign w_rdir = r_dir;
`else
  assign w_sdir = 1'b0;
  assign w_rdir = 1'b0;
`endif

  assign w_ce        = r_pre == PW'(CE_DIV - 1);
  assign w_frame_end = w_ce && r_phase == 3'd7;
  assign w_full      = r_len == (AW+1)'(MSG_DEPTH);
  assign w_wr        = bus.wr_en && !bus.clear && r_state != RUN && !w_full;
  assign w_go        = bus.start && r_len != '0;
  assign w_lastpos   = AW'(r_len - 1'b1);
  assign w_first     = w_sdir ? w_lastpos : '0;
  assign w_wrap      = w_rdir ? w_lastpos : '0;
  assign w_next      = w_rdir ? r_idx - 1'b1 : r_idx + 1'b1;
  assign w_at_end    = r_idx == (w_rdir ? '0 : w_lastpos);

  // clear > stop > start > frame-driven advance; writes are handled beside the FSM
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_dwell = r_dwell;
    w_seq   = r_seq;
    w_done  = 1'b0;
    if (bus.clear || bus.stop) begin
      w_state = IDLE;
      w_seq   = IDLE_DIGIT;
    end else if (w_go) begin
      w_state = RUN;
      w_idx   = w_first;
      w_dwell = '0;
      w_seq   = r_buf[w_first];
    end else if (r_state == RUN && w_frame_end) begin
      w_dwell = r_dwell == DW'(DWELL_FRAMES - 1) ? '0 : r_dwell + 1'b1;
      if (r_dwell == DW'(DWELL_FRAMES - 1)) begin
        if (!w_at_end) begin
          w_idx = w_next;
          w_seq = r_buf[w_next];
        end else if (bus.loop) begin
          w_idx = w_wrap;
          w_seq = r_buf[w_wrap];
        end else begin
          w_state = DONE;
          w_done  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre   <= '0;
      r_phase <= '0;
      r_state <= IDLE;
      r_idx   <= '0;
      r_dwell <= '0;
      r_seq   <= IDLE_DIGIT;
      r_done  <= 1'b0;
      r_len   <= '0;
    end else begin
      r_pre   <= w_ce ? '0 : r_pre + 1'b1;
      r_phase <= r_phase + 3'(w_ce);
      r_state <= w_state;
      r_idx   <= w_idx;
      r_dwell <= w_dwell;
      r_seq   <= w_seq;
      r_done  <= w_done;
      r_len   <= bus.clear ? '0 : r_len + (AW+1)'(w_wr);
    end
  end

  always_ff @(posedge clk)
    if (w_wr) r_buf[r_len[AW-1:0]] <= bus.wr_data;

  assign bus.ce      = w_ce;
  assign bus.seq     = r_seq;
  assign bus.busy    = r_state == RUN;
  assign bus.done    = r_done;
  assign bus.full    = w_full;
  assign bus.msg_len = r_len;
endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// tb_matrix_seq_ctrl: directed vectors for matrix_seq_ctrl with CE_DIV=2, DWELL_FRAMES=2, MSG_DEPTH=4.
module tb_matrix_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_seq_ctrl_if #(.MSG_DEPTH(4)) bus ();
  matrix_seq_ctrl #(.CE_DIV(2), .DWELL_FRAMES(2), .MSG_DEPTH(4), .IDLE_DIGIT(4'h0))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic       r, we;
    logic [3:0] wd;
    logic       cl, st, sp, lp;
    logic       ce;
    logic [3:0] seq;
    logic       busy, full;
    logic [2:0] len;
  } vec_t;

  vec_t v [14];
  int   errors = 0;
  int   checks = 0;
  int   k = 0;
  logic saw_done = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, k);
    end
  endtask

  // k counts rising edges since the most recent reset edge
  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    if (bus.done === 1'b1) saw_done = 1'b1;
  endtask

  task automatic run_to(input int n);
    while (k < n) tick();
  endtask

  task automatic outs(input string tag, input logic [3:0] s, input logic b, input logic d);
    chk({tag, ".seq"}, 8'(bus.seq), 8'(s));
    chk({tag, ".busy"}, 8'(bus.busy), 8'(b));
    chk({tag, ".done"}, 8'(bus.done), 8'(d));
  endtask

  initial begin
`ifdef MATRIX_SEQ_REVERSE_EN
    bus.dir = 1'b0;
`endif
    bus.wr_en = 0; bus.wr_data = 0; bus.clear = 0; bus.start = 0; bus.stop = 0; bus.loop = 0;
    //         r  we wd    cl st sp lp  ce seq   busy full len
    v[0]  = '{1, 0, 4'h0, 0, 0, 0, 0,  0, 4'h0, 0, 0, 3'd0};
    v[1]  = '{0, 0, 4'h0, 0, 0, 0, 0,  1, 4'h0, 0, 0, 3'd0};
    v[2]  = '{0, 1, 4'hA, 0, 0, 0, 0,  0, 4'h0, 0, 0, 3'd1};
    v[3]  = '{0, 1, 4'h3, 0, 0, 0, 0,  1, 4'h0, 0, 0, 3'd2};
    v[4]  = '{0, 1, 4'hF, 0, 0, 0, 0,  0, 4'h0, 0, 0, 3'd3};
    v[5]  = '{0, 1, 4'h0, 0, 0, 0, 0,  1, 4'h0, 0, 1, 3'd4};
    v[6]  = '{0, 1, 4'h7, 0, 0, 0, 0,  0, 4'h0, 0, 1, 3'd4};
    v[7]  = '{0, 1, 4'h5, 1, 0, 0, 0,  1, 4'h0, 0, 0, 3'd0};
    v[8]  = '{0, 0, 4'h0, 0, 1, 0, 0,  0, 4'h0, 0, 0, 3'd0};
    v[9]  = '{0, 1, 4'h5, 0, 0, 0, 0,  1, 4'h0, 0, 0, 3'd1};
    v[10] = '{0, 1, 4'hB, 0, 0, 0, 0,  0, 4'h0, 0, 0, 3'd2};
    v[11] = '{0, 0, 4'h0, 0, 1, 0, 0,  1, 4'h5, 1, 0, 3'd2};
    v[12] = '{0, 1, 4'h9, 0, 0, 0, 0,  0, 4'h5, 1, 0, 3'd2};
    v[13] = '{0, 0, 4'h0, 0, 0, 0, 0,  1, 4'h5, 1, 0, 3'd2};
    for (int i = 0; i < 14; i++) begin
      rst = v[i].r; bus.wr_en = v[i].we; bus.wr_data = v[i].wd; bus.clear = v[i].cl;
      bus.start = v[i].st; bus.stop = v[i].sp; bus.loop = v[i].lp;
      tick();
      if (v[i].r) k = 0;
      chk($sformatf("v%0d.ce", i), 8'(bus.ce), 8'(v[i].ce));
      chk($sformatf("v%0d.seq", i), 8'(bus.seq), 8'(v[i].seq));
      chk($sformatf("v%0d.busy", i), 8'(bus.busy), 8'(v[i].busy));
      chk($sformatf("v%0d.full", i), 8'(bus.full), 8'(v[i].full));
      chk($sformatf("v%0d.len", i), 8'(bus.msg_len), 8'(v[i].len));
      chk($sformatf("v%0d.done", i), 8'(bus.done), 8'(0));
    end
    rst = 0; bus.wr_en = 0; bus.start = 0; bus.loop = 0;

    // one-shot playback of 5,B started at edge 11; frame_end edges fall on multiples of 16
    run_to(31); outs("once31", 4'h5, 1, 0);
    run_to(32); outs("once32", 4'hB, 1, 0);
    run_to(63); outs("once63", 4'hB, 1, 0);
    run_to(64); outs("once64", 4'hB, 0, 1);
    run_to(65); outs("once65", 4'hB, 0, 0);

    saw_done = 1'b0;
    bus.loop = 1; bus.start = 1;
    tick(); bus.start = 0;
    outs("loop66", 4'h5, 1, 0);
    run_to(95);  outs("loop95", 4'h5, 1, 0);
    run_to(96);  outs("loop96", 4'hB, 1, 0);
    run_to(127); outs("loop127", 4'hB, 1, 0);
    run_to(128); outs("loop128", 4'h5, 1, 0);
    run_to(160); outs("loop160", 4'hB, 1, 0);
    chk("loop.no_done", 8'(saw_done), 8'(0));
    bus.stop = 1;
    tick(); bus.stop = 0;
    outs("stop161", 4'h0, 0, 0);

    bus.start = 1;
    tick();
    outs("restart162", 4'h5, 1, 0);
    bus.stop = 1;
    tick(); bus.start = 0; bus.stop = 0;
    outs("startstop163", 4'h0, 0, 0);

    bus.start = 1;
    tick(); bus.start = 0;
    outs("run164", 4'h5, 1, 0);
    run_to(175);
    chk("pre_rst.ce", 8'(bus.ce), 8'(1));
    rst = 1;
    tick(); rst = 0; k = 0;
    outs("rst", 4'h0, 0, 0);
    chk("rst.ce", 8'(bus.ce), 8'(0));
    chk("rst.full", 8'(bus.full), 8'(0));
    chk("rst.len", 8'(bus.msg_len), 8'(0));
    tick(); chk("rst1.ce", 8'(bus.ce), 8'(1));
    tick(); chk("rst2.ce", 8'(bus.ce), 8'(0));
    outs("rst2", 4'h0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
